// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with one-byte valid/ready holding register
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_in,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_nbits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_nstops,
    output logic [7:0]       rx_data,
    output logic [3:0]       rx_status,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err_falsestart
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ser_s;
    logic                   ser_prev;
    logic [DIV_W-1:0]       tick_cnt;
    logic [DIV_W-1:0]       div_last;
    logic                   tick;
    logic                   start_edge;
    logic                   mid;
    logic [3:0]             bit_tick;
    logic [2:0]             bit_idx;
    logic [2:0]             last_idx;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   nstops_q;
    logic [7:0]             data_q;
    logic                   badpar_q;
    logic                   badstop_q;
    logic                   done_q;
    logic                   overrun;

    assign ser_s      = sync_q[SYNC_STAGES-1];
    assign div_last   = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick       = (tick_cnt == div_last);
    assign start_edge = (state == IDLE) && ser_prev && !ser_s;
    assign mid        = tick && (bit_tick == 4'd7);
    assign overrun    = rx_valid && !rx_ready;

    // Idle-high line: synchroniser and edge history reset to 1 so reset release is not a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= '1;
            ser_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ser_in};
            ser_prev <= ser_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (start_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // States advance at each mid-bit sample; the next sample is then exactly 16 ticks later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bit_tick       <= '0;
            bit_idx        <= '0;
            last_idx       <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            nstops_q       <= 1'b0;
            data_q         <= '0;
            badpar_q       <= 1'b0;
            badstop_q      <= 1'b0;
            done_q         <= 1'b0;
            err_falsestart <= 1'b0;
        end else begin
            err_falsestart <= 1'b0;
            done_q         <= 1'b0;
            if (state != IDLE && tick) begin
                bit_tick <= bit_tick + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= START;
                        bit_tick  <= '0;
                        bit_idx   <= '0;
                        last_idx  <= 3'd4 + {1'b0, cfg_nbits};
                        par_en_q  <= cfg_parity_en;
                        par_odd_q <= cfg_parity_odd;
                        nstops_q  <= cfg_nstops;
                        data_q    <= '0;
                        badpar_q  <= 1'b0;
                        badstop_q <= 1'b0;
                    end
                end
                START: begin
                    if (mid) begin
                        if (ser_s) begin
                            err_falsestart <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        data_q[bit_idx] <= ser_s;
                        if (bit_idx == last_idx) begin
                            state <= par_en_q ? PARITY : STOP1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        badpar_q <= ((^data_q) ^ ser_s) != par_odd_q;
                        state    <= STOP1;
                    end
                end
                STOP1: begin
                    if (mid) begin
                        if (!ser_s) begin
                            badstop_q <= 1'b1;
                        end
                        if (nstops_q) begin
                            state <= STOP2;
                        end else begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (mid) begin
                        if (!ser_s) begin
                            badstop_q <= 1'b1;
                        end
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_status <= '0;
            rx_valid  <= 1'b0;
        end else if (done_q) begin
            rx_data   <= data_q;
            rx_status <= {overrun, badstop_q, badpar_q, !(badpar_q || badstop_q || overrun)};
            rx_valid  <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule
